// File: rtl/baud_tick_if.sv
// Baud tick generator bus: configuration/control inputs and tick outputs.
//
// Signals
//   enable   : counting enable; low freezes the phase
//   restart  : synchronous clear of phase (counters, accumulator)
//   load     : single-cycle request to adopt div_int/div_frac
//   div_int  : integer divisor, oversample period base = div_int+1 cycles
//   div_frac : fractional divisor numerator (units of 1/2^FRAC_BITS)
//   os_tick  : one-cycle oversample tick
//   mid_tick : one-cycle tick at the mid-bit sample point
//   bit_tick : one-cycle tick once per bit period
//   div_ack  : one-cycle pulse when a loaded divisor becomes active
//
// master = configuration side (drives controls, consumes ticks)
// slave  = the generator itself
interface baud_tick_if #(
   parameter int DIV_INT_BITS = 16,
   parameter int FRAC_BITS    = 4
);
   logic                    enable;
   logic                    restart;
   logic                    load;
   logic [DIV_INT_BITS-1:0] div_int;
   logic [FRAC_BITS-1:0]    div_frac;
   logic                    os_tick;
   logic                    mid_tick;
   logic                    bit_tick;
   logic                    div_ack;

   modport master (
      output enable, restart, load, div_int, div_frac,
      input  os_tick, mid_tick, bit_tick, div_ack
   );

   modport slave (
      input  enable, restart, load, div_int, div_frac,
      output os_tick, mid_tick, bit_tick, div_ack
   );
endinterface

// File: rtl/baud_tick_generator.sv
// Fractional baud tick generator.
//
// Produces an oversampling tick (os_tick), a mid-bit sample tick (mid_tick)
// and a bit-rate tick (bit_tick) from one system clock. The oversample period
// is act_int+1 cycles, stretched by one cycle whenever the fractional
// accumulator carries, so the average period is act_int+1+act_frac/2^FRAC_BITS.
// A divisor written through load is held pending and only adopted at a period
// boundary, while disabled, or on restart, so a period is never cut short or
// lengthened mid-way by a reload.
//
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : baud_tick_if.slave (controls in, ticks and div_ack out)
//
// The interface instance must use the same DIV_INT_BITS/FRAC_BITS as this
// module.
module baud_tick_generator #(
   parameter int DIV_INT_BITS = 16,
   parameter int FRAC_BITS    = 4,
   parameter int OVERSAMPLE   = 16,
   parameter int OS_CNT_BITS  = 4
) (
   input  logic        clk,
   input  logic        reset,
   baud_tick_if.slave  bus
);

   // One extra bit so act_int = max with a stretch cycle does not wrap.
   localparam int CW = DIV_INT_BITS + 1;

   localparam logic [OS_CNT_BITS-1:0] OS_LAST = OS_CNT_BITS'(OVERSAMPLE - 1);
   localparam logic [OS_CNT_BITS-1:0] OS_MID  = OS_CNT_BITS'(OVERSAMPLE / 2 - 1);

   // Phase state
   logic [CW-1:0]           cnt;
   logic [FRAC_BITS-1:0]    acc;
   logic                    stretch;
   logic [OS_CNT_BITS-1:0]  os_cnt;

   // Divisor state
   logic [DIV_INT_BITS-1:0] act_int;
   logic [FRAC_BITS-1:0]    act_frac;
   logic [DIV_INT_BITS-1:0] pend_int;
   logic [FRAC_BITS-1:0]    pend_frac;
   logic                    pending;

   // Combinational
   logic                    run;
   logic [CW-1:0]           limit;
   logic                    period_end;
   logic [FRAC_BITS:0]      frac_sum;
   logic                    os_wrap;
   logic                    os_half;
   logic                    apply;
   logic [DIV_INT_BITS-1:0] nxt_int;
   logic [FRAC_BITS-1:0]    nxt_frac;

   always_comb begin
      run   = bus.enable & ~bus.restart;
      limit = {1'b0, act_int} + {{DIV_INT_BITS{1'b0}}, stretch};
      // >= rather than == so a divisor shrunk while disabled (cnt already
      // past the new limit) ends the period at once instead of wrapping.
      period_end = run & (cnt >= limit);
      frac_sum   = {1'b0, acc} + {1'b0, act_frac};
      os_wrap    = (os_cnt == OS_LAST);
      os_half    = (os_cnt == OS_MID);
      // A load in the same cycle as an application point bypasses the
      // pending registers and takes the live inputs.
      apply      = (bus.load | pending) & (bus.restart | ~bus.enable | period_end);
      nxt_int    = bus.load ? bus.div_int  : pend_int;
      nxt_frac   = bus.load ? bus.div_frac : pend_frac;
   end

   // Period counter, fractional accumulator and oversample counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         acc     <= '0;
         stretch <= 1'b0;
         os_cnt  <= '0;
      end else if (bus.restart) begin
         cnt     <= '0;
         acc     <= '0;
         stretch <= 1'b0;
         os_cnt  <= '0;
      end else if (bus.enable) begin
         if (period_end) begin
            cnt            <= '0;
            {stretch, acc} <= frac_sum;   // carry lengthens the next period
            os_cnt         <= os_wrap ? '0 : os_cnt + OS_CNT_BITS'(1);
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Registered tick outputs; all derived from period_end so no sub-tick can
   // appear without os_tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.os_tick  <= 1'b0;
         bus.mid_tick <= 1'b0;
         bus.bit_tick <= 1'b0;
         bus.div_ack  <= 1'b0;
      end else begin
         bus.os_tick  <= period_end;
         bus.mid_tick <= period_end & os_half;
         bus.bit_tick <= period_end & os_wrap;
         bus.div_ack  <= apply;
      end
   end

   // Divisor staging: pending copy plus the active copy used by the counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         act_int   <= '0;
         act_frac  <= '0;
         pend_int  <= '0;
         pend_frac <= '0;
         pending   <= 1'b0;
      end else begin
         if (bus.load) begin
            pend_int  <= bus.div_int;
            pend_frac <= bus.div_frac;
         end
         if (apply) begin
            act_int  <= nxt_int;
            act_frac <= nxt_frac;
            pending  <= 1'b0;
         end else if (bus.load) begin
            pending  <= 1'b1;
         end
      end
   end

endmodule
